// File: rtl/dcache_op_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_op_engine_pkg
//  Purpose  : Shared types and constants for the cache-maintenance engine:
//             CACHE op codes, tag-array entry layout and default geometry.
//  Revision : 1.0  initial release
// ============================================================================
package dcache_op_engine_pkg;

    localparam int CACHE_INDEX_W    = 8;
    localparam int CACHE_TAG_W      = 20;
    localparam int CACHE_LINE_WORDS = 4;

    typedef enum logic [2:0] {
        OP_INDEX_INV       = 3'd0,
        OP_INDEX_STORE_TAG = 3'd1,
        OP_HIT_INV         = 3'd2,
        OP_D_INDEX_WB_INV  = 3'd3,
        OP_D_HIT_WB_INV    = 3'd4
    } cache_op_t;

    typedef struct packed {
        logic                   v;
        logic                   d;
        logic [CACHE_TAG_W-1:0] tag;
    } cache_tag_entry_t;

    // Hit ops select the way by tag compare rather than by req_way
    function automatic logic op_is_hit(input cache_op_t op);
        return (op == OP_HIT_INV) || (op == OP_D_HIT_WB_INV);
    endfunction

    // Writeback ops drain a dirty target line before invalidating it
    function automatic logic op_is_wb(input cache_op_t op);
        return (op == OP_D_INDEX_WB_INV) || (op == OP_D_HIT_WB_INV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_op_engine.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_op_engine
//  Purpose  : Sequences MIPS CACHE maintenance ops on the tag/data arrays:
//             tag read, hit check, dirty-line drain to memory, tag rewrite.
//  Revision : 1.0  initial release
// ============================================================================
module dcache_op_engine
    import dcache_op_engine_pkg::*;
#(
    parameter int INDEX_W    = CACHE_INDEX_W,
    parameter int TAG_W      = CACHE_TAG_W,
    parameter int LINE_WORDS = CACHE_LINE_WORDS
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               req_valid,
    output logic               req_ready,
    input  cache_op_t          req_op,
    input  logic [INDEX_W-1:0] req_index,
    input  logic               req_way,
    input  logic [TAG_W-1:0]   req_tag,
    input  logic               req_v,
    input  logic               req_d,
    output logic               tag_en,
    output logic               tag_we,
    output logic [INDEX_W-1:0] tag_index,
    output logic               tag_way,
    output logic [TAG_W+1:0]   tag_wdata,
    input  logic [TAG_W+1:0]   tag_rdata0,
    input  logic [TAG_W+1:0]   tag_rdata1,
    output logic               data_en,
    output logic [INDEX_W-1:0] data_index,
    output logic               data_way,
    output logic [1:0]         data_word,
    input  logic [31:0]        data_rdata,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [31:0]        wb_addr,
    output logic [31:0]        wb_data,
    output logic               wb_last,
    input  logic               wb_bdone,
    output logic               op_done
);

    localparam int OFF_W = $clog2(LINE_WORDS * 4);
    localparam int CNT_W = $clog2(LINE_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(LINE_WORDS);
    localparam logic [1:0]       LAST_BEAT = 2'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TAG_RD  = 3'd1,
        ST_CHECK   = 3'd2,
        ST_LINE_RD = 3'd3,
        ST_TAG_WR  = 3'd4,
        ST_WB_SEND = 3'd5,
        ST_WB_RESP = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_state_n;

    // Request fields captured at accept
    cache_op_t          r_op;
    logic [INDEX_W-1:0] r_index;
    logic               r_way;
    logic [TAG_W-1:0]   r_tag;
    logic               r_v;
    logic               r_d;

    // Target line resolved in CHECK (or taken from the request for store-tag)
    logic               r_tgt_way;
    logic [TAG_W-1:0]   r_tgt_tag;
    logic               r_line_rd;

    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_beat;
    logic [31:0]        r_line_buf [LINE_WORDS];

    logic               w_hit0;
    logic               w_hit1;
    logic               w_found;
    logic               w_sel_way;
    logic [TAG_W+1:0]   w_sel_entry;
    logic               w_need_wb;
    logic [1:0]         w_cap_idx;
    logic               w_last_beat;
    logic [31:0]        w_line_addr;

    assign w_hit0      = tag_rdata0[TAG_W+1] && (tag_rdata0[TAG_W-1:0] == r_tag);
    assign w_hit1      = tag_rdata1[TAG_W+1] && (tag_rdata1[TAG_W-1:0] == r_tag);
    // Read data lags the address by one cycle, so capture slot is cnt-1
    assign w_cap_idx   = r_cnt[1:0] - 2'd1;
    assign w_last_beat = (r_beat == LAST_BEAT);
    assign w_line_addr = {r_tgt_tag, r_index, {OFF_W{1'b0}}};

    // Target way selection and writeback decision from the tag read data
    always_comb begin
        w_found   = 1'b1;
        w_sel_way = r_way;
        if (op_is_hit(r_op)) begin
            w_found   = w_hit0 || w_hit1;
            w_sel_way = !w_hit0;          // way 0 wins when both ways hit
        end
        w_sel_entry = w_sel_way ? tag_rdata1 : tag_rdata0;
        w_need_wb   = op_is_wb(r_op) && w_sel_entry[TAG_W+1] && w_sel_entry[TAG_W];
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state and array/writeback port drive; ports are quiet outside their states
    always_comb begin
        w_state_n  = r_state;
        req_ready  = 1'b0;
        tag_en     = 1'b0;
        tag_we     = 1'b0;
        tag_index  = '0;
        tag_way    = 1'b0;
        tag_wdata  = '0;
        data_en    = 1'b0;
        data_index = '0;
        data_way   = 1'b0;
        data_word  = '0;
        wb_valid   = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        wb_last    = 1'b0;
        op_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_n = (req_op == OP_INDEX_STORE_TAG) ? ST_TAG_WR : ST_TAG_RD;
                end
            end
            ST_TAG_RD: begin
                tag_en    = 1'b1;
                tag_index = r_index;
                w_state_n = ST_CHECK;
            end
            ST_CHECK: begin
                if (!w_found) begin
                    w_state_n = ST_DONE;
                end else if (w_need_wb) begin
                    w_state_n = ST_LINE_RD;
                end else begin
                    w_state_n = ST_TAG_WR;
                end
            end
            ST_LINE_RD: begin
                if (r_cnt != LAST_CNT) begin
                    data_en    = 1'b1;
                    data_index = r_index;
                    data_way   = r_tgt_way;
                    data_word  = r_cnt[1:0];
                end else begin
                    w_state_n = ST_TAG_WR;
                end
            end
            ST_TAG_WR: begin
                tag_en    = 1'b1;
                tag_we    = 1'b1;
                tag_index = r_index;
                tag_way   = r_tgt_way;
                tag_wdata = (r_op == OP_INDEX_STORE_TAG) ? {r_v, r_d, r_tag}
                                                         : {2'b00, r_tgt_tag};
                w_state_n = r_line_rd ? ST_WB_SEND : ST_DONE;
            end
            ST_WB_SEND: begin
                wb_valid = 1'b1;
                wb_addr  = w_line_addr;
                wb_data  = r_line_buf[r_beat];
                wb_last  = w_last_beat;
                if (wb_ready && w_last_beat) begin
                    w_state_n = ST_WB_RESP;
                end
            end
            ST_WB_RESP: begin
                if (wb_bdone) begin
                    w_state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                op_done   = 1'b1;
                w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // Request latch, target resolution, line-read counter, buffer and beat counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op      <= OP_INDEX_INV;
            r_index   <= '0;
            r_way     <= 1'b0;
            r_tag     <= '0;
            r_v       <= 1'b0;
            r_d       <= 1'b0;
            r_tgt_way <= 1'b0;
            r_tgt_tag <= '0;
            r_line_rd <= 1'b0;
            r_cnt     <= '0;
            r_beat    <= '0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_line_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op      <= req_op;
                        r_index   <= req_index;
                        r_way     <= req_way;
                        r_tag     <= req_tag;
                        r_v       <= req_v;
                        r_d       <= req_d;
                        r_tgt_way <= req_way;
                        r_tgt_tag <= req_tag;
                        r_line_rd <= 1'b0;
                        r_cnt     <= '0;
                        r_beat    <= '0;
                    end
                end
                ST_CHECK: begin
                    r_tgt_way <= w_sel_way;
                    r_tgt_tag <= w_sel_entry[TAG_W-1:0];
                    r_line_rd <= w_need_wb;
                end
                ST_LINE_RD: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt != '0) begin
                        r_line_buf[w_cap_idx] <= data_rdata;
                    end
                end
                ST_WB_SEND: begin
                    if (wb_ready) begin
                        r_beat <= r_beat + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_op_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_dcache_op_engine
//  Purpose  : Scoreboard bench for dcache_op_engine with tag/data array and
//             writeback memory models.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dcache_op_engine;
    import dcache_op_engine_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    cache_op_t   req_op = OP_INDEX_INV;
    logic [7:0]  req_index = '0;
    logic        req_way = 1'b0;
    logic [19:0] req_tag = '0;
    logic        req_v = 1'b0;
    logic        req_d = 1'b0;
    logic        tag_en, tag_we, tag_way;
    logic [7:0]  tag_index;
    logic [21:0] tag_wdata;
    logic [21:0] tag_rdata0 = '0;
    logic [21:0] tag_rdata1 = '0;
    logic        data_en, data_way;
    logic [7:0]  data_index;
    logic [1:0]  data_word;
    logic [31:0] data_rdata = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [31:0] wb_addr, wb_data;
    logic        wb_last;
    logic        wb_bdone = 1'b0;
    logic        op_done;

    dcache_op_engine #(.INDEX_W(8), .TAG_W(20), .LINE_WORDS(4)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_index(req_index), .req_way(req_way), .req_tag(req_tag),
        .req_v(req_v), .req_d(req_d),
        .tag_en(tag_en), .tag_we(tag_we), .tag_index(tag_index), .tag_way(tag_way),
        .tag_wdata(tag_wdata), .tag_rdata0(tag_rdata0), .tag_rdata1(tag_rdata1),
        .data_en(data_en), .data_index(data_index), .data_way(data_way),
        .data_word(data_word), .data_rdata(data_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_last(wb_last), .wb_bdone(wb_bdone),
        .op_done(op_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rdy_mode = 0;

    logic [30:0] exp_tw [$];   // {way, index, wdata}
    logic [64:0] exp_bt [$];   // {addr, data, last}
    int          exp_dn [$];   // op_done latency from accept, -1 = not timed

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Array models: one writer for the arrays, fed by the DUT or the preload task
    logic [21:0] tag_mem [0:1][0:255];
    logic [31:0] dat_mem [0:1][0:255][0:3];
    logic        pl_we = 1'b0;
    logic        pl_way = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [21:0] pl_tag = '0;
    logic [31:0] pl_dat [0:3];

    always @(posedge clk) begin
        if (tag_en && !tag_we) begin
            tag_rdata0 <= tag_mem[0][tag_index];
            tag_rdata1 <= tag_mem[1][tag_index];
        end
        if (tag_en && tag_we) tag_mem[tag_way][tag_index] <= tag_wdata;
        if (data_en) data_rdata <= dat_mem[data_way][data_index][data_word];
        if (pl_we) begin
            tag_mem[pl_way][pl_idx] <= pl_tag;
            for (int k = 0; k < 4; k++) dat_mem[pl_way][pl_idx][k] <= pl_dat[k];
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready) acc_cyc <= cyc;
    end

    // Memory side: ready pattern and a write response two cycles after the last beat
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) wb_ready = 1'b1;
        else               wb_ready = 1'($urandom_range(0, 1));
    end

    int pend = 0;
    always @(negedge clk) begin
        if (!resetn) begin
            pend = 0;
            wb_bdone = 1'b0;
        end else begin
            wb_bdone = 1'b0;
            if (pend != 0) begin
                pend--;
                if (pend == 0) wb_bdone = 1'b1;
            end
            if (wb_valid && wb_ready && wb_last) pend = 2;
        end
    end

    // Monitor: pops expected tag writes, beats and completions as the DUT presents them
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] prev_addr = '0;
    always @(negedge clk) begin
        logic [30:0] etw;
        logic [64:0] ebt;
        int          edn;
        if (!resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (tag_we) begin
                if (exp_tw.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tag_write unexpected: way=%0d idx=%0h data=%0h", tag_way, tag_index, tag_wdata);
                end else begin
                    etw = exp_tw.pop_front();
                    chk("tag_write", {tag_way, tag_index, tag_wdata}, etw);
                end
            end
            if (wb_valid && wb_ready) begin
                if (exp_bt.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_beat unexpected: addr=%0h data=%0h last=%0d", wb_addr, wb_data, wb_last);
                end else begin
                    ebt = exp_bt.pop_front();
                    chk("wb_beat", {wb_addr, wb_data, wb_last}, ebt);
                end
            end
            if (prev_stall) begin
                chk("stall_hold", {wb_valid, wb_addr, wb_data}, {1'b1, prev_addr, prev_data});
            end
            prev_stall = wb_valid && !wb_ready;
            prev_data  = wb_data;
            prev_addr  = wb_addr;
            if (op_done) begin
                if (exp_dn.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL op_done unexpected at cycle %0d", cyc);
                end else begin
                    edn = exp_dn.pop_front();
                    if (edn >= 0) chk("done_latency", cyc - acc_cyc, edn);
                end
            end
        end
    end

    task automatic preload(input logic way, input logic [7:0] idx, input cache_tag_entry_t e,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
        @(negedge clk);
        pl_way = way; pl_idx = idx; pl_tag = e;
        pl_dat[0] = w0; pl_dat[1] = w1; pl_dat[2] = w2; pl_dat[3] = w3;
        pl_we = 1'b1;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic push_beats(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
        exp_bt.push_back({a, w0, 1'b0});
        exp_bt.push_back({a, w1, 1'b0});
        exp_bt.push_back({a, w2, 1'b0});
        exp_bt.push_back({a, w3, 1'b1});
    endtask

    task automatic issue(input cache_op_t op, input logic [7:0] idx, input logic way,
                         input logic [19:0] tag, input logic v, input logic d);
        @(negedge clk); #1;
        req_op = op; req_index = idx; req_way = way; req_tag = tag;
        req_v = v; req_d = d; req_valid = 1'b1;
        @(negedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_tw.size() != 0 || exp_bt.size() != 0 || exp_dn.size() != 0 || !req_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL %s timeout: pending tw=%0d beats=%0d done=%0d", name, exp_tw.size(), exp_bt.size(), exp_dn.size());
            exp_tw.delete(); exp_bt.delete(); exp_dn.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_tag_en", {tag_en, tag_we}, 0);
        chk("rst_data_en", data_en, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_op_done", op_done, 0);
        #2 resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Store-tag: {v=1,d=0,tag} to idx 0x12 way 1, done 2 cycles after accept
        exp_tw.push_back({1'b1, 8'h12, 1'b1, 1'b0, 20'hABCDE});
        exp_dn.push_back(2);
        issue(OP_INDEX_STORE_TAG, 8'h12, 1'b1, 20'hABCDE, 1'b1, 1'b0);
        wait_idle("store_tag");

        // Hit writeback-invalidate on dirty way 0, zero-wait memory
        preload(1'b0, 8'h05, {1'b1, 1'b1, 20'h00400}, 32'h11, 32'h22, 32'h33, 32'h44);
        preload(1'b1, 8'h05, {1'b1, 1'b1, 20'h00401}, 32'h55, 32'h66, 32'h77, 32'h88);
        exp_tw.push_back({1'b0, 8'h05, 2'b00, 20'h00400});
        push_beats(32'h00400050, 32'h11, 32'h22, 32'h33, 32'h44);
        exp_dn.push_back(15);
        issue(OP_D_HIT_WB_INV, 8'h05, 1'b1, 20'h00400, 1'b0, 1'b0);
        wait_idle("hit_wb_inv");

        // Hit-invalidate miss: way 1 matches the tag but is invalid
        preload(1'b0, 8'h07, {1'b1, 1'b0, 20'h11111}, 0, 0, 0, 0);
        preload(1'b1, 8'h07, {1'b0, 1'b1, 20'h12345}, 0, 0, 0, 0);
        exp_dn.push_back(3);
        issue(OP_HIT_INV, 8'h07, 1'b0, 20'h12345, 1'b0, 1'b0);
        wait_idle("hit_miss");

        // Index writeback-invalidate on a clean valid line: invalidate only
        preload(1'b1, 8'h09, {1'b1, 1'b0, 20'h0BEEF}, 1, 2, 3, 4);
        exp_tw.push_back({1'b1, 8'h09, 2'b00, 20'h0BEEF});
        exp_dn.push_back(4);
        issue(OP_D_INDEX_WB_INV, 8'h09, 1'b1, 20'h00000, 1'b0, 1'b0);
        wait_idle("index_wb_clean");

        // Both ways hit: way 0 is chosen
        preload(1'b0, 8'h20, {1'b1, 1'b0, 20'h33333}, 0, 0, 0, 0);
        preload(1'b1, 8'h20, {1'b1, 1'b1, 20'h33333}, 0, 0, 0, 0);
        exp_tw.push_back({1'b0, 8'h20, 2'b00, 20'h33333});
        exp_dn.push_back(4);
        issue(OP_HIT_INV, 8'h20, 1'b1, 20'h33333, 1'b0, 1'b0);
        wait_idle("double_hit");

        // Index-invalidate of a dirty line at the top index: no writeback
        preload(1'b1, 8'hFF, {1'b1, 1'b1, 20'h5A5A5}, 9, 9, 9, 9);
        exp_tw.push_back({1'b1, 8'hFF, 2'b00, 20'h5A5A5});
        exp_dn.push_back(4);
        issue(OP_INDEX_INV, 8'hFF, 1'b1, 20'h00000, 1'b0, 1'b0);
        wait_idle("index_inv");

        // Hit writeback on way 1 with a randomly stalling memory
        preload(1'b0, 8'h30, {1'b1, 1'b1, 20'hAAAAA}, 0, 0, 0, 0);
        preload(1'b1, 8'h30, {1'b1, 1'b1, 20'hFFFFF}, 32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF);
        exp_tw.push_back({1'b1, 8'h30, 2'b00, 20'hFFFFF});
        push_beats(32'hFFFFF300, 32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF);
        exp_dn.push_back(-1);
        rdy_mode = 1;
        issue(OP_D_HIT_WB_INV, 8'h30, 1'b0, 20'hFFFFF, 1'b0, 1'b0);
        wait_idle("wb_stall");
        rdy_mode = 0;
        repeat (2) @(negedge clk);

        // Reset while the second beat is on the bus
        preload(1'b0, 8'h40, {1'b1, 1'b1, 20'h0ABCD}, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        exp_tw.push_back({1'b0, 8'h40, 2'b00, 20'h0ABCD});
        push_beats(32'h0ABCD400, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        exp_dn.push_back(-1);
        issue(OP_D_INDEX_WB_INV, 8'h40, 1'b0, 20'h00000, 1'b0, 1'b0);
        n = 0;
        while (!(wb_valid && wb_data == 32'hA1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL reach_beat2 timeout: wb_valid=%0d wb_data=%0h", wb_valid, wb_data);
        end
        #2 resetn = 1'b0;
        #1;
        chk("midrst_wb_valid", wb_valid, 0);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_ports", {tag_en, data_en, op_done}, 0);
        exp_bt.delete();
        exp_dn.delete();
        exp_tw.delete();
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Store-tag after reset release, index 0 with v=1 d=1
        exp_tw.push_back({1'b0, 8'h00, 2'b11, 20'hFFFFF});
        exp_dn.push_back(2);
        issue(OP_INDEX_STORE_TAG, 8'h00, 1'b0, 20'hFFFFF, 1'b1, 1'b1);
        wait_idle("store_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
